// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB-first, one bit per clock,
// through a single full-adder cell (two half-adder stages plus an OR) and a
// carry flip-flop. A start/done handshake frames each operation, and the
// result registers only change on the completing edge or on reset.

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic ha1_sum;
    logic ha1_cout;
    logic ha2_sum;
    logic ha2_cout;
    logic fa_cout;
    logic last_bit;

    // Full-adder cell built from two half-adders and an OR, plus the accumulator shift-in value
    always_comb begin
        ha1_sum  = op_a[0] ^ op_b[0];
        ha1_cout = op_a[0] & op_b[0];
        ha2_sum  = ha1_sum ^ carry;
        ha2_cout = ha1_sum & carry;
        fa_cout  = ha1_cout | ha2_cout;
        acc_next = WIDTH'({ha2_sum, acc} >> 1);
        last_bit = (cnt == LAST);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start is only honoured in IDLE, DONE always returns to IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ADD;
            ADD:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded purely from the state register, so start never reaches them combinationally
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Datapath: capture operands on an accepted start, shift one bit per ADD cycle, publish on the last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            Sum   <= '0;
            Cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= A;
                        op_b  <= B;
                        carry <= Cin;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                ADD: begin
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    carry <= fa_cout;
                    acc   <= acc_next;
                    cnt   <= cnt + 1'b1;
                    if (last_bit) begin
                        Sum  <= acc_next;
                        Cout <= fa_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: an 8-bit and a 1-bit instance are
// compared every cycle against a timeline/arithmetic model of the handshake,
// with hand-computed literal results pinning the model on directed cases.
`timescale 1ns/1ps

module tb_serial_adder;

    localparam int W8 = 8;
    localparam int W1 = 1;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int checks    = 0;
    int failures  = 0;
    int done_cnt8 = 0;
    int done_cnt1 = 0;

    // Model state: phase 0 = idle, 1..W = bit cycles, W+1 = done cycle
    int         phase8;
    int         phase1;
    logic [8:0] pend8;
    logic [8:0] res8;
    logic [1:0] pend1;
    logic [1:0] res1;

    serial_adder #(.WIDTH(W8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .A     (a8),
        .B     (b8),
        .Cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .Sum   (sum8),
        .Cout  (cout8)
    );

    serial_adder #(.WIDTH(W1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .A     (a1),
        .B     (b1),
        .Cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .Sum   (sum1),
        .Cout  (cout1)
    );

    always #5 clk = ~clk;

    // Behavioural model: result is plain A+B+Cin, published WIDTH edges after the start edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase8 <= 0;
            pend8  <= '0;
            res8   <= '0;
            phase1 <= 0;
            pend1  <= '0;
            res1   <= '0;
        end else begin
            if (phase8 == 0) begin
                if (start8) begin
                    phase8 <= 1;
                    pend8  <= 9'(a8) + 9'(b8) + 9'(cin8);
                end
            end else if (phase8 <= W8) begin
                phase8 <= phase8 + 1;
                if (phase8 == W8) res8 <= pend8;
            end else begin
                phase8 <= 0;
            end

            if (phase1 == 0) begin
                if (start1) begin
                    phase1 <= 1;
                    pend1  <= 2'(a1) + 2'(b1) + 2'(cin1);
                end
            end else if (phase1 <= W1) begin
                phase1 <= phase1 + 1;
                if (phase1 == W1) res1 <= pend1;
            end else begin
                phase1 <= 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput;
        check("busy8",   32'(busy8), 32'(phase8 != 0));
        check("done8",   32'(done8), 32'(phase8 == W8 + 1));
        check("result8", 32'({cout8, sum8}), 32'(res8));
        check("busy1",   32'(busy1), 32'(phase1 != 0));
        check("done1",   32'(done1), 32'(phase1 == W1 + 1));
        check("result1", 32'({cout1, sum1}), 32'(res1));
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
        if (done8) done_cnt8++;
        if (done1) done_cnt1++;
        checkOutput();
    endtask

    task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                                  input logic [8:0] exp, input logic [8:0] prev);
        int n;
        start8 = 1'b1;
        a8 = a;
        b8 = b;
        cin8 = cin;
        tick();
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        cin8 = 1'($urandom);
        check("held8", 32'({cout8, sum8}), 32'(prev));
        n = 0;
        while (!done8 && n < 40) begin
            tick();
            n++;
        end
        check("latency8", 32'(n), 32'(W8));
        check("model8", 32'(res8), 32'(exp));
        check("sum8", 32'({cout8, sum8}), 32'(exp));
        tick();
    endtask

    task automatic applyStimulus1(input logic a, input logic b, input logic cin,
                                  input logic [1:0] exp, input logic [1:0] prev);
        int n;
        start1 = 1'b1;
        a1 = a;
        b1 = b;
        cin1 = cin;
        tick();
        start1 = 1'b0;
        a1 = 1'($urandom);
        b1 = 1'($urandom);
        cin1 = 1'($urandom);
        check("held1", 32'({cout1, sum1}), 32'(prev));
        n = 0;
        while (!done1 && n < 10) begin
            tick();
            n++;
        end
        check("latency1", 32'(n), 32'(W1));
        check("model1", 32'(res1), 32'(exp));
        check("sum1", 32'({cout1, sum1}), 32'(exp));
        tick();
    endtask

    // Directed cases, mid-run restart and reset, then randomized traffic on both instances
    initial begin
        logic [1:0] tt1 [8];
        logic [8:0] prev8;
        logic [8:0] exp8;
        logic [1:0] prev1;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        int         n;
        int         dc0;

        tt1 = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

        rst_n  = 1'b0;
        start8 = 1'b0;
        a8     = '0;
        b8     = '0;
        cin8   = 1'b0;
        start1 = 1'b0;
        a1     = '0;
        b1     = '0;
        cin1   = 1'b0;

        repeat (2) tick();
        check("reset_busy8", 32'(busy8), 32'd0);
        check("reset_done8", 32'(done8), 32'd0);
        check("reset_sum8",  32'({cout8, sum8}), 32'd0);
        check("reset_sum1",  32'({busy1, done1, cout1, sum1}), 32'd0);
        rst_n = 1'b1;
        tick();

        applyStimulus8(8'h3C, 8'h5A, 1'b0, 9'h096, 9'h000);
        applyStimulus8(8'hFF, 8'h01, 1'b0, 9'h100, 9'h096);
        applyStimulus8(8'hFF, 8'hFF, 1'b1, 9'h1FF, 9'h100);

        // Start re-pulsed three edges into a run must be ignored
        dc0 = done_cnt8;
        start8 = 1'b1;
        a8 = 8'h3C;
        b8 = 8'h5A;
        cin8 = 1'b0;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        start8 = 1'b1;
        a8 = 8'h00;
        b8 = 8'h00;
        tick();
        start8 = 1'b0;
        n = 3;
        while (!done8 && n < 40) begin
            tick();
            n++;
        end
        check("repulse_latency", 32'(n), 32'd8);
        check("repulse_sum", 32'({cout8, sum8}), 32'h096);
        repeat (4) tick();
        check("repulse_done_count", 32'(done_cnt8 - dc0), 32'd1);

        // Asynchronous reset mid-run clears outputs at once and abandons the run
        start8 = 1'b1;
        a8 = 8'h11;
        b8 = 8'h22;
        tick();
        start8 = 1'b0;
        repeat (3) tick();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_busy8", 32'(busy8), 32'd0);
        check("async_done8", 32'(done8), 32'd0);
        check("async_sum8",  32'({cout8, sum8}), 32'd0);
        @(negedge clk);
        checkOutput();
        tick();
        rst_n = 1'b1;
        dc0 = done_cnt8;
        repeat (12) tick();
        check("no_done_after_reset", 32'(done_cnt8 - dc0), 32'd0);
        applyStimulus8(8'h01, 8'h02, 1'b0, 9'h003, 9'h000);

        // Back-to-back: second start in the first IDLE cycle after done
        applyStimulus8(8'h10, 8'h20, 1'b0, 9'h030, 9'h003);
        applyStimulus8(8'h80, 8'h80, 1'b0, 9'h100, 9'h030);

        prev8 = 9'h100;
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            exp8 = 9'(ra) + 9'(rb) + 9'(rc);
            applyStimulus8(ra, rb, rc, exp8, prev8);
            prev8 = exp8;
        end

        prev1 = 2'd0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus1(i[2], i[1], i[0], tt1[i], prev1);
            prev1 = tt1[i];
        end

        // Random start pulses and operand churn on both instances, checked every cycle
        for (int i = 0; i < 400; i++) begin
            start8 = ($urandom_range(0, 3) == 0);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            cin8 = 1'($urandom);
            start1 = ($urandom_range(0, 2) == 0);
            a1 = 1'($urandom);
            b1 = 1'($urandom);
            cin1 = 1'($urandom);
            tick();
        end
        start8 = 1'b0;
        start1 = 1'b0;
        repeat (12) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
